// File: rtl/reg_bank16.sv
// reg_bank16: 16 x WIDTH register bank with busy scoreboard.
// Optional same-cycle write forwarding: REG_BANK16_BYPASS_EN.

module reg_bank16_mux16 #(
    parameter int W = 64
) (
    input  logic [15:0][W-1:0] din,
    input  logic [3:0]         sel,
    output logic [W-1:0]       dout
);

    // 16:1 bus select
    always_comb begin
        dout = '0;
        unique case (sel)
            4'd0:  dout = din[0];
            4'd1:  dout = din[1];
            4'd2:  dout = din[2];
            4'd3:  dout = din[3];
            4'd4:  dout = din[4];
            4'd5:  dout = din[5];
            4'd6:  dout = din[6];
            4'd7:  dout = din[7];
            4'd8:  dout = din[8];
            4'd9:  dout = din[9];
            4'd10: dout = din[10];
            4'd11: dout = din[11];
            4'd12: dout = din[12];
            4'd13: dout = din[13];
            4'd14: dout = din[14];
            4'd15: dout = din[15];
        endcase
    end

endmodule

module reg_bank16 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [3:0]       rsv_addr,
    output logic             rsv_stall,
    input  logic [3:0]       rd_addr_a,
    input  logic [3:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_ready_a,
    output logic             rd_ready_b,
    output logic [15:0]      busy
);

    localparam logic [3:0] ZIDX     = 4'hF;
    localparam bit         HAS_ZERO = (ZERO_REG != 0);

    logic [15:0][WIDTH-1:0] mem_q;
    logic [15:0]            busy_q;
    logic [15:0]            busy_d;

    logic             wr_zero;
    logic             rsv_zero;
    logic             wr_ok;
    logic             rsv_same;
    logic             rsv_ok;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] raw_b;

    assign wr_zero  = HAS_ZERO && (wr_addr == ZIDX);
    assign rsv_zero = HAS_ZERO && (rsv_addr == ZIDX);
    assign wr_ok    = wr_en & ~wr_zero;
    assign rsv_same = wr_en & (wr_addr == rsv_addr);

    // a write-back to the same index frees the slot for the new producer
    assign rsv_stall = rsv_en & busy_q[rsv_addr] & ~rsv_same;
    assign rsv_ok    = rsv_en & ~rsv_stall & ~rsv_zero;

`ifdef REG_BANK16_BYPASS_EN
    assign fwd_a = reset_n & wr_ok & (wr_addr == rd_addr_a);
    assign fwd_b = reset_n & wr_ok & (wr_addr == rd_addr_b);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    // register contents, zero register never written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // scoreboard next state: clear on write-back, then set on reserve
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (HAS_ZERO) begin
            busy_d[15] = 1'b0;
        end
    end

    // scoreboard register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    reg_bank16_mux16 #(.W(WIDTH)) u_mux_a (
        .din  (mem_q),
        .sel  (rd_addr_a),
        .dout (raw_a)
    );

    reg_bank16_mux16 #(.W(WIDTH)) u_mux_b (
        .din  (mem_q),
        .sel  (rd_addr_b),
        .dout (raw_b)
    );

    // read port a: stored value, optional forward, zero register override
    always_comb begin
        rd_data_a  = raw_a;
        rd_ready_a = ~busy_q[rd_addr_a];
        if (fwd_a) begin
            rd_data_a  = wr_data;
            rd_ready_a = 1'b1;
        end
        if (HAS_ZERO && (rd_addr_a == ZIDX)) begin
            rd_data_a  = '0;
            rd_ready_a = 1'b1;
        end
    end

    // read port b: stored value, optional forward, zero register override
    always_comb begin
        rd_data_b  = raw_b;
        rd_ready_b = ~busy_q[rd_addr_b];
        if (fwd_b) begin
            rd_data_b  = wr_data;
            rd_ready_b = 1'b1;
        end
        if (HAS_ZERO && (rd_addr_b == ZIDX)) begin
            rd_data_b  = '0;
            rd_ready_b = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_bank16.sv
// tb_reg_bank16: directed table, corner sequences and
// randomized traffic against an array-based reference.

module tb_reg_bank16;

`ifdef REG_BANK16_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        rsv_stall;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        rd_ready_a;
    logic        rd_ready_b;
    logic [15:0] busy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_mem [16];
    bit          m_busy[16];

    reg_bank16 #(.WIDTH(64), .ZERO_REG(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rsv_stall  (rsv_stall),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_ready_a (rd_ready_a),
        .rd_ready_b (rd_ready_b),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [63:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        stall;
        logic [15:0] bsy;
        logic [63:0] da;
        logic        ya;
        logic [63:0] db;
        logic        yb;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(
        input logic we, input logic [3:0] wa, input logic [63:0] wd,
        input logic re, input logic [3:0] ra,
        input logic [3:0] a, input logic [3:0] b,
        input logic st, input logic [15:0] bs,
        input logic [63:0] da, input logic ya,
        input logic [63:0] db, input logic yb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.a = a; v.b = b; v.stall = st; v.bsy = bs;
        v.da = da; v.ya = ya; v.db = db; v.yb = yb;
        return v;
    endfunction

    function automatic logic [63:0] bv(input int i);
        return 64'h1111_0000 + 64'(i);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic we, input logic [3:0] wa,
                         input logic [63:0] wd, input logic re,
                         input logic [3:0] ra, input logic [3:0] a,
                         input logic [3:0] b);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd_addr_a = a; rd_addr_b = b;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic bit m_stall();
        return rsv_en && m_busy[rsv_addr] &&
               !(wr_en && wr_addr == rsv_addr);
    endfunction

    task automatic edge_clk();
        bit st;
        st = m_stall();
        @(posedge clk);
        if (wr_en && wr_addr != 4'd15) begin
            m_mem[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (rsv_en && !st && rsv_addr != 4'd15)
            m_busy[rsv_addr] = 1'b1;
        #1;
    endtask

    task automatic exp_rd(input logic [3:0] ad, output logic [63:0] d,
                          output logic y);
        if (ad == 4'd15) begin
            d = '0; y = 1'b1;
        end else if (BYP && wr_en && wr_addr == ad) begin
            d = wr_data; y = 1'b1;
        end else begin
            d = m_mem[ad]; y = !m_busy[ad];
        end
    endtask

    task automatic mcheck();
        logic [63:0] d;
        logic        y;
        logic [15:0] bs;
        for (int i = 0; i < 16; i++) bs[i] = m_busy[i];
        exp_rd(rd_addr_a, d, y);
        chk("rnd_data_a", rd_data_a, d);
        chk("rnd_ready_a", 64'(rd_ready_a), 64'(y));
        exp_rd(rd_addr_b, d, y);
        chk("rnd_data_b", rd_data_b, d);
        chk("rnd_ready_b", 64'(rd_ready_b), 64'(y));
        chk("rnd_stall", 64'(rsv_stall), 64'(m_stall()));
        chk("rnd_busy", 64'(busy), 64'(bs));
    endtask

    initial begin
        reset_n = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #12;
        reset_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ready_a", 64'(rd_ready_a), 64'h1);
        chk("rst_data_a", rd_data_a, 64'h0);

        @(posedge clk); #1;
        apply(1, 3, 64'hDEAD, 1, 9, 3, 9);
        edge_clk();
        apply(0, 0, 0, 0, 0, 3, 9);
        chk("pre_rst_data", rd_data_a, 64'hDEAD);
        chk("pre_rst_busy", 64'(busy), 64'h0200);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data_a", rd_data_a, 64'h0);
        chk("mid_rst_ready_a", 64'(rd_ready_a), 64'h1);
        chk("mid_rst_ready_b", 64'(rd_ready_b), 64'h1);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_stall", 64'(rsv_stall), 64'h0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            apply(1, 4'(i), bv(i), 0, 0, 4'd15, 4'd15);
            edge_clk();
        end
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 0, 0, 0, 4'(i), 4'(15 - i));
            chk("rb_a", rd_data_a, (i == 15) ? 64'h0 : bv(i));
            chk("rb_b", rd_data_b, (i == 0) ? 64'h0 : bv(15 - i));
        end

        tv[0]  = mk(0,0,0,1,5, 5,0, 0,16'h0000, bv(5),1, bv(0),1);
        tv[1]  = mk(0,0,0,0,0, 5,0, 0,16'h0020, bv(5),0, bv(0),1);
        tv[2]  = mk(1,5,64'hABCD,0,0, 6,1, 0,16'h0020, bv(6),1, bv(1),1);
        tv[3]  = mk(0,0,0,0,0, 5,6, 0,16'h0000, 64'hABCD,1, bv(6),1);
        tv[4]  = mk(0,0,0,1,7, 7,0, 0,16'h0000, bv(7),1, bv(0),1);
        tv[5]  = mk(0,0,0,1,7, 7,0, 1,16'h0080, bv(7),0, bv(0),1);
        tv[6]  = mk(1,7,64'h77,1,7, 3,4, 0,16'h0080, bv(3),1, bv(4),1);
        tv[7]  = mk(0,0,0,0,0, 7,3, 0,16'h0080, 64'h77,0, bv(3),1);
        tv[8]  = mk(1,15,64'hFFFF,1,15, 15,15, 0,16'h0080, 0,1, 0,1);
        tv[9]  = mk(0,0,0,0,0, 15,7, 0,16'h0080, 0,1, 64'h77,0);
        tv[10] = mk(1,7,64'h7777,1,2, 1,3, 0,16'h0080, bv(1),1, bv(3),1);
        tv[11] = mk(0,0,0,0,0, 2,7, 0,16'h0004, bv(2),0, 64'h7777,1);
        tv[12] = mk(1,2,64'h2222,0,0, 0,1, 0,16'h0004, bv(0),1, bv(1),1);
        tv[13] = mk(0,0,0,0,0, 2,0, 0,16'h0000, 64'h2222,1, bv(0),1);

        for (int r = 0; r < 14; r++) begin
            apply(tv[r].we, tv[r].wa, tv[r].wd, tv[r].re, tv[r].ra,
                  tv[r].a, tv[r].b);
            chk($sformatf("tv%0d_stall", r), 64'(rsv_stall), 64'(tv[r].stall));
            chk($sformatf("tv%0d_busy", r), 64'(busy), 64'(tv[r].bsy));
            chk($sformatf("tv%0d_da", r), rd_data_a, tv[r].da);
            chk($sformatf("tv%0d_ya", r), 64'(rd_ready_a), 64'(tv[r].ya));
            chk($sformatf("tv%0d_db", r), rd_data_b, tv[r].db);
            chk($sformatf("tv%0d_yb", r), 64'(rd_ready_b), 64'(tv[r].yb));
            edge_clk();
        end

        apply(1, 2, 64'h55AA, 0, 0, 0, 2);
        chk("byp_same_cycle", rd_data_b, BYP ? 64'h55AA : 64'h2222);
        chk("byp_same_ready", 64'(rd_ready_b), 64'h1);
        edge_clk();
        apply(0, 0, 0, 0, 0, 0, 2);
        chk("byp_next_cycle", rd_data_b, 64'h55AA);

        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            mcheck();
            edge_clk();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
